// File: rtl/line_plotter.sv
// rtl/line_plotter.sv - Bresenham line plotter for a 160x120 VGA framebuffer; optional CLEAR_SCREEN_EN adds a full-screen clear
module line_plotter (
    input  logic       clk,
    input  logic       reset,
`ifdef CLEAR_SCREEN_EN
    input  logic       clear,
`endif
    input  logic       start,
    input  logic [7:0] x0,
    input  logic [7:0] x1,
    input  logic [6:0] y0,
    input  logic [6:0] y1,
    input  logic [2:0] colour_in,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAW  = 2'd1,
        S_DONE  = 2'd2
`ifdef CLEAR_SCREEN_EN
        , S_CLEAR = 2'd3
`endif
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [7:0]  r_x;
    logic [6:0]  r_y;
    logic [7:0]  r_x1;
    logic [6:0]  r_y1;
    logic [2:0]  r_colour;
    logic [10:0] r_dx;
    logic [10:0] r_dy;
    logic [10:0] r_err;
    logic        r_sx_neg;
    logic        r_sy_neg;

    logic [7:0]  w_x0c;
    logic [7:0]  w_x1c;
    logic [6:0]  w_y0c;
    logic [6:0]  w_y1c;
    logic [7:0]  w_dx_abs;
    logic [6:0]  w_dy_abs;
    logic [10:0] w_dx_init;
    logic [10:0] w_dy_init;
    logic [11:0] w_e2;
    logic        w_step_x;
    logic        w_step_y;
    logic [10:0] w_err_next;
    logic        w_at_end;
    logic        w_clear_req;
    logic        w_start_line;

    // Clamp endpoints into the visible area before anything is derived from them
    assign w_x0c = (x0 > 8'd159) ? 8'd159 : x0;
    assign w_x1c = (x1 > 8'd159) ? 8'd159 : x1;
    assign w_y0c = (y0 > 7'd119) ? 7'd119 : y0;
    assign w_y1c = (y1 > 7'd119) ? 7'd119 : y1;

    assign w_dx_abs  = (w_x0c < w_x1c) ? (w_x1c - w_x0c) : (w_x0c - w_x1c);
    assign w_dy_abs  = (w_y0c < w_y1c) ? (w_y1c - w_y0c) : (w_y0c - w_y1c);
    assign w_dx_init = {3'b000, w_dx_abs};
    assign w_dy_init = 11'd0 - {4'b0000, w_dy_abs};

    // e2 is twice err; one extra bit keeps it exact for every legal line
    assign w_e2       = {r_err, 1'b0};
    assign w_step_x   = $signed(w_e2) >= $signed({r_dy[10], r_dy});
    assign w_step_y   = $signed(w_e2) <= $signed({r_dx[10], r_dx});
    assign w_err_next = r_err + (w_step_x ? r_dy : 11'd0) + (w_step_y ? r_dx : 11'd0);
    assign w_at_end   = (r_x == r_x1) && (r_y == r_y1);

`ifdef CLEAR_SCREEN_EN
    assign w_clear_req = clear;
`else
    assign w_clear_req = 1'b0;
`endif
    // A clear request in the same cycle takes priority and drops the line request
    assign w_start_line = start && !w_clear_req;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
`ifdef CLEAR_SCREEN_EN
                if (w_clear_req)       w_next = S_CLEAR;
                else
`endif
                if (w_start_line)      w_next = S_DRAW;
            end
            S_DRAW:  if (w_at_end)     w_next = S_DONE;
`ifdef CLEAR_SCREEN_EN
            S_CLEAR: if ((r_x == 8'd159) && (r_y == 7'd119)) w_next = S_DONE;
`endif
            S_DONE:                    w_next = S_IDLE;
            default:                   w_next = S_IDLE;
        endcase
    end

    // Datapath: latch a line in IDLE, walk Bresenham in DRAW, raster-sweep in CLEAR
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x      <= 8'd0;
            r_y      <= 7'd0;
            r_x1     <= 8'd0;
            r_y1     <= 7'd0;
            r_colour <= 3'd0;
            r_dx     <= 11'd0;
            r_dy     <= 11'd0;
            r_err    <= 11'd0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
`ifdef CLEAR_SCREEN_EN
                    if (w_clear_req) begin
                        r_x      <= 8'd0;
                        r_y      <= 7'd0;
                        r_colour <= 3'd0;
                    end else
`endif
                    if (w_start_line) begin
                        r_x      <= w_x0c;
                        r_y      <= w_y0c;
                        r_x1     <= w_x1c;
                        r_y1     <= w_y1c;
                        r_colour <= colour_in;
                        r_dx     <= w_dx_init;
                        r_dy     <= w_dy_init;
                        r_err    <= w_dx_init + w_dy_init;
                        r_sx_neg <= !(w_x0c < w_x1c);
                        r_sy_neg <= !(w_y0c < w_y1c);
                    end
                end
                S_DRAW: begin
                    if (!w_at_end) begin
                        r_err <= w_err_next;
                        if (w_step_x) r_x <= r_x + (r_sx_neg ? 8'hFF : 8'h01);
                        if (w_step_y) r_y <= r_y + (r_sy_neg ? 7'h7F : 7'h01);
                    end
                end
`ifdef CLEAR_SCREEN_EN
                S_CLEAR: begin
                    if (r_x == 8'd159) begin
                        if (r_y != 7'd119) begin
                            r_x <= 8'd0;
                            r_y <= r_y + 7'd1;
                        end
                    end else begin
                        r_x <= r_x + 8'd1;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    assign x      = r_x;
    assign y      = r_y;
    assign colour = r_colour;
`ifdef CLEAR_SCREEN_EN
    assign plot   = (r_state == S_DRAW) || (r_state == S_CLEAR);
`else
    assign plot   = (r_state == S_DRAW);
`endif
    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_DONE);

endmodule
